pingpong_frame_scheduler: RTL and testbench

//  Sequences the 1-bit ping-pong SPRAM frame buffer: turns raw camera pixel strobes into

---
 rtl/pingpong_frame_scheduler.sv | 177 +++++++++++++++++
 tb/tb_pingpong_frame_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_scheduler.sv
// pingpong_frame_scheduler
//  Sequences a 1-bit ping-pong frame buffer. Camera pixel strobes become
//  registered write address/data/enable; completed frames are handed to the
//  SPI reader through a req/grant/done handshake, and the buffers only swap
//  while the reader does not hold the read buffer. Lost frames are counted.
// Ports
//  clk, reset                 clock, synchronous active-high reset
//  cam_frame_start            1-cycle start-of-frame pulse
//  cam_pix_valid/cam_pix_data pixel strobe and thresholded pixel bit
//  wr_addr/wr_data/wr_en      registered pixel write to the buffer
//  frame_done                 1-cycle pulse: buffer toggles its select
//  buf_select                 mirror of the buffer select (0 = camera on buf0)
//  rd_req/rd_grant/rd_done    reader handshake
//  frame_ready                an unread complete frame is in the read buffer
//  frames_dropped             saturating count of undelivered frames
module pingpong_frame_scheduler #(
  parameter int FRAME_PIXELS = 76800,
  parameter int ADDR_W       = 17,
  parameter int DROP_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_frame_start,
  input  logic              cam_pix_valid,
  input  logic              cam_pix_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic              buf_select,
  input  logic              rd_req,
  output logic              rd_grant,
  input  logic              rd_done,
  output logic              frame_ready,
  output logic [DROP_W-1:0] frames_dropped
);

  typedef enum logic [2:0] {W_WAIT_SOF, W_CAPTURE, W_PAD, W_DONE, W_HOLD} wstate_t;
  typedef enum logic [1:0] {R_EMPTY, R_READY, R_BUSY} rstate_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

  wstate_t             wstate_q, wstate_d;
  rstate_t             rstate_q, rstate_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                wr_en_q, wr_en_d;
  logic                wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                buf_sel_q, buf_sel_d;
  logic                rd_grant_q, rd_grant_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [1:0]          drop_inc;
  logic [DROP_W:0]     drop_sum;
  logic                swap;

  always_comb begin
    wstate_d     = wstate_q;
    rstate_d     = rstate_q;
    count_d      = count_q;
    wr_addr_d    = wr_addr_q;
    wr_en_d      = 1'b0;
    wr_data_d    = 1'b0;
    frame_done_d = 1'b0;
    buf_sel_d    = buf_sel_q;
    rd_grant_d   = 1'b0;
    drop_inc     = 2'd0;

    // A finishing rd_done frees the read buffer in the same cycle, so a held
    // frame swaps immediately instead of waiting a cycle for R_EMPTY.
    swap = ((wstate_q == W_DONE) || (wstate_q == W_HOLD)) &&
           ((rstate_q != R_BUSY) || rd_done);

    case (wstate_q)
      W_WAIT_SOF: begin
        if (cam_frame_start) begin
          wstate_d = W_CAPTURE;
          count_d  = '0;
        end
      end
      W_CAPTURE: begin
        if (cam_pix_valid && count_q == LAST_PIX) begin
          // final pixel wins over a coincident SOF; that SOF is lost
          wr_en_d   = 1'b1;
          wr_addr_d = count_q;
          wr_data_d = cam_pix_data;
          wstate_d  = W_DONE;
          if (cam_frame_start) drop_inc = 2'd1;
        end else if (cam_frame_start) begin
          drop_inc = 2'd1;
          if (count_q[3:0] != 4'd0) wstate_d = W_PAD;
          else                      count_d  = '0;
        end else if (cam_pix_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q;
          wr_data_d = cam_pix_data;
          count_d   = count_q + 1'b1;
        end
      end
      W_PAD: begin
        // fill the buffer's 16-bit packer with zeros so the next frame
        // starts on a word boundary
        wr_en_d   = 1'b1;
        wr_addr_d = count_q;
        count_d   = count_q + 1'b1;
        if (count_d[3:0] == 4'd0) begin
          wstate_d = W_CAPTURE;
          count_d  = '0;
        end
      end
      W_DONE, W_HOLD: begin
        if (cam_frame_start) drop_inc = 2'd1;
        if (swap) begin
          frame_done_d = 1'b1;
          buf_sel_d    = ~buf_sel_q;
          wstate_d     = W_WAIT_SOF;
        end else begin
          wstate_d = W_HOLD;
        end
      end
      default: wstate_d = W_WAIT_SOF;
    endcase

    case (rstate_q)
      R_EMPTY: if (swap) rstate_d = R_READY;
      R_READY: begin
        if (swap) begin
          drop_inc = 2'(drop_inc + 2'd1);   // unread frame overwritten
        end else if (rd_req) begin
          rd_grant_d = 1'b1;
          rstate_d   = R_BUSY;
        end
      end
      R_BUSY: if (rd_done) rstate_d = swap ? R_READY : R_EMPTY;
      default: rstate_d = R_EMPTY;
    endcase

    drop_sum = {1'b0, drop_q} + (DROP_W+1)'(drop_inc);
    drop_d   = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate_q     <= W_WAIT_SOF;
      rstate_q     <= R_EMPTY;
      count_q      <= '0;
      wr_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 1'b0;
      frame_done_q <= 1'b0;
      buf_sel_q    <= 1'b0;
      rd_grant_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      count_q      <= count_d;
      wr_addr_q    <= wr_addr_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      buf_sel_q    <= buf_sel_d;
      rd_grant_q   <= rd_grant_d;
      drop_q       <= drop_d;
    end
  end

  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign wr_en          = wr_en_q;
  assign frame_done     = frame_done_q;
  assign buf_select     = buf_sel_q;
  assign rd_grant       = rd_grant_q;
  assign frame_ready    = (rstate_q == R_READY);
  assign frames_dropped = drop_q;

endmodule

// File: tb/tb_pingpong_frame_scheduler.sv
// Bench for pingpong_frame_scheduler with a 32-pixel frame: a table of
// directed vectors with spec-derived expectations, a few hand sequences,
// and randomized traffic checked every cycle against a frame-level model.
module tb_pingpong_frame_scheduler;
  localparam int FP = 32;
  localparam int AW = 6;
  localparam int DW = 3;
  localparam int DMAX = (1 << DW) - 1;

  logic clk = 1'b0, reset = 1'b0;
  logic sof = 1'b0, pv = 1'b0, pd = 1'b0, req = 1'b0, done = 1'b0;
  logic [AW-1:0] wr_addr;
  logic wr_data, wr_en, frame_done, buf_select, rd_grant, frame_ready;
  logic [DW-1:0] frames_dropped;

  pingpong_frame_scheduler #(.FRAME_PIXELS(FP), .ADDR_W(AW), .DROP_W(DW)) dut (
    .clk(clk), .reset(reset), .cam_frame_start(sof), .cam_pix_valid(pv),
    .cam_pix_data(pd), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .frame_done(frame_done), .buf_select(buf_select), .rd_req(req),
    .rd_grant(rd_grant), .rd_done(done), .frame_ready(frame_ready),
    .frames_dropped(frames_dropped));

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;

  // model: what the camera side is doing and who owns the finished frame
  bit m_cap, m_pad, m_full, m_unread, m_locked, m_bs;
  int m_cnt, m_drop;
  bit e_we, e_data, e_fd, e_grant;
  int e_addr;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_pad = 0; m_full = 0; m_unread = 0; m_locked = 0; m_bs = 0;
    m_cnt = 0; m_drop = 0; e_we = 0; e_data = 0; e_fd = 0; e_grant = 0; e_addr = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input bit d, input bit r, input bit dn);
    int inc = 0;
    bit swap;
    bit o_unread = m_unread, o_locked = m_locked;
    e_we = 0; e_data = 0; e_fd = 0; e_grant = 0;
    swap = m_full && (!o_locked || dn);
    if (o_locked && dn) m_locked = 0;
    if (swap) begin
      if (o_unread) inc++;
      m_unread = 1;
    end else if (o_unread && r) begin
      e_grant = 1; m_unread = 0; m_locked = 1;
    end
    if (m_full) begin
      if (s) inc++;
      if (swap) begin m_full = 0; e_fd = 1; m_bs = !m_bs; end
    end else if (m_pad) begin
      e_we = 1; e_addr = m_cnt; e_data = 0; m_cnt++;
      if (m_cnt % 16 == 0) begin m_pad = 0; m_cnt = 0; end
    end else if (m_cap) begin
      if (v && m_cnt == FP - 1) begin
        e_we = 1; e_addr = m_cnt; e_data = d; m_cap = 0; m_full = 1;
        if (s) inc++;
      end else if (s) begin
        inc++;
        if (m_cnt % 16 != 0) m_pad = 1; else m_cnt = 0;
      end else if (v) begin
        e_we = 1; e_addr = m_cnt; e_data = d; m_cnt++;
      end
    end else if (s) begin
      m_cap = 1; m_cnt = 0;
    end
    m_drop = (m_drop + inc > DMAX) ? DMAX : m_drop + inc;
  endtask

  task automatic cmp_model();
    chk("wr_en", wr_en, e_we);
    if (e_we) begin
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
    end
    chk("frame_done", frame_done, e_fd);
    chk("buf_select", buf_select, m_bs);
    chk("rd_grant", rd_grant, e_grant);
    chk("frame_ready", frame_ready, m_unread);
    chk("frames_dropped", frames_dropped, m_drop);
    chk("fd_with_wr_en", frame_done & wr_en, 0);
  endtask

  // one cycle: drive at negedge, model on posedge, compare at next negedge
  task automatic apply(input bit s, input bit v, input bit d, input bit r, input bit dn);
    sof = s; pv = v; pd = d; req = r; done = dn;
    @(posedge clk);
    model_step(s, v, d, r, dn);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    sof = 0; pv = 0; pd = 0; req = 0; done = 0; reset = 1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 0;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_buf_select", buf_select, 0);
    chk("rst_rd_grant", rd_grant, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_dropped", frames_dropped, 0);
  endtask

  typedef struct {
    bit s, v, d, r, dn;
    int n;
    bit we; int addr; bit data, fd, bs, gnt, rdy; int drop;
  } vec_t;

  vec_t tbl[20];

  initial begin
    //          s v d r dn  n   we addr d fd bs g rdy drop
    tbl[0]  = '{0,0,0,0,0,  1,  0, 0, 0,0, 0,0,0, 0};
    tbl[1]  = '{1,0,0,0,0,  1,  0, 0, 0,0, 0,0,0, 0};
    tbl[2]  = '{0,1,1,0,0, 31,  1,30, 1,0, 0,0,0, 0};
    tbl[3]  = '{0,1,0,0,0,  1,  1,31, 0,0, 0,0,0, 0};
    tbl[4]  = '{0,0,0,0,0,  1,  0,31, 0,1, 1,0,1, 0};   // swap 1 cycle after last write
    tbl[5]  = '{0,0,0,1,0,  1,  0,31, 0,0, 1,1,0, 0};   // grant
    tbl[6]  = '{1,0,0,0,0,  1,  0,31, 0,0, 1,0,0, 0};
    tbl[7]  = '{0,1,1,0,0, 32,  1,31, 1,0, 1,0,0, 0};
    tbl[8]  = '{0,0,0,0,0,  3,  0,31, 0,0, 1,0,0, 0};   // held while reader busy
    tbl[9]  = '{0,0,0,0,1,  1,  0,31, 0,1, 0,0,1, 0};   // rd_done releases swap
    tbl[10] = '{0,0,0,0,0,  1,  0,31, 0,0, 0,0,1, 0};
    tbl[11] = '{1,0,0,0,0,  1,  0,31, 0,0, 0,0,1, 0};
    tbl[12] = '{0,1,1,0,0, 20,  1,19, 1,0, 0,0,1, 0};
    tbl[13] = '{1,0,0,0,0,  1,  0,19, 0,0, 0,0,1, 1};   // short frame
    tbl[14] = '{0,1,1,0,0, 12,  1,31, 0,0, 0,0,1, 1};   // pad, pixels ignored
    tbl[15] = '{0,1,1,0,0,  1,  1, 0, 1,0, 0,0,1, 1};   // restart at 0
    tbl[16] = '{0,1,0,0,0, 31,  1,31, 0,0, 0,0,1, 1};
    tbl[17] = '{0,0,0,1,0,  1,  0,31, 0,1, 1,0,1, 2};   // swap beats req, overwrite
    tbl[18] = '{0,0,0,1,0,  1,  0,31, 0,0, 1,1,0, 2};   // grant next cycle
    tbl[19] = '{0,0,0,0,1,  1,  0,31, 0,0, 1,0,0, 2};

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++)
        apply(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].dn);
      chk($sformatf("t%0d_wr_en", i), wr_en, tbl[i].we);
      chk($sformatf("t%0d_wr_addr", i), wr_addr, tbl[i].addr);
      chk($sformatf("t%0d_wr_data", i), wr_data, tbl[i].data);
      chk($sformatf("t%0d_frame_done", i), frame_done, tbl[i].fd);
      chk($sformatf("t%0d_buf_select", i), buf_select, tbl[i].bs);
      chk($sformatf("t%0d_rd_grant", i), rd_grant, tbl[i].gnt);
      chk($sformatf("t%0d_frame_ready", i), frame_ready, tbl[i].rdy);
      chk($sformatf("t%0d_dropped", i), frames_dropped, tbl[i].drop);
    end

    // reset mid-capture at count 10 with buf_select = 1
    apply(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) apply(0, 1, 1, 0, 0);
    chk("mid_addr", wr_addr, 9);
    chk("mid_buf_select", buf_select, 1);
    pv = 1;
    do_reset();

    // frame_done on the last pixel's SOF: pixel written, SOF counted as drop
    apply(1, 0, 0, 0, 0);
    for (int k = 0; k < FP - 1; k++) apply(0, 1, 1, 0, 0);
    apply(1, 1, 1, 0, 0);
    chk("sof_last_wr_addr", wr_addr, FP - 1);
    chk("sof_last_dropped", frames_dropped, 1);
    apply(0, 0, 0, 0, 0);
    chk("sof_last_frame_done", frame_done, 1);

    // randomized traffic with a reader that holds req until granted
    begin
      bit r = 0;
      for (int c = 0; c < 4000; c++) begin
        bit s, v, dn;
        s  = ($urandom_range(0, 29) == 0);
        v  = ($urandom_range(0, 3) != 0);
        dn = ($urandom_range(0, 5) == 0);
        if (!r && $urandom_range(0, 7) == 0) r = 1;
        apply(s, v, $urandom_range(0, 1) == 1, r, dn);
        if (rd_grant) r = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
